// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: FSM state type, IR field positions and the x0 select
// shared by the operand fetch stage.
`default_nettype none

package operand_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;

  localparam int X0 = 0;

endpackage

`default_nettype wire

// File: rtl/operand_select.sv
// operand_select: one operand path; x0 forcing, write-port hazard detect and,
// when OPERAND_FETCH_BYPASS_EN is defined, write-port bypass.
`default_nettype none

module operand_select
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SELECT_SIZE = 5
) (
  input  logic [SELECT_SIZE-1:0] sel,
  input  logic [DATA_WIDTH-1:0]  rf_data,
  input  logic                   wb_we_ni,
  input  logic [SELECT_SIZE-1:0] wb_dst,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  output logic [DATA_WIDTH-1:0]  value,
  output logic                   hazard
);

  logic is_x0;

  assign is_x0  = (sel == SELECT_SIZE'(X0));
  assign hazard = !wb_we_ni && (wb_dst != SELECT_SIZE'(X0)) && (wb_dst == sel);

`ifdef OPERAND_FETCH_BYPASS_EN
  // A write in flight to this select beats the stale register file read.
  assign value = hazard ? wb_data : (is_x0 ? '0 : rf_data);
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign value = is_x0 ? '0 : rf_data;
`endif

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// operand_fetch: IDLE/READ/HOLD operand fetch stage with register file snoop.
// Optional feature macro: OPERAND_FETCH_BYPASS_EN (write-port bypass).
`default_nettype none

module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SELECT_SIZE = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [31:0]            ir_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output logic [SELECT_SIZE-1:0] reg_srcA_o,
  output logic [SELECT_SIZE-1:0] reg_srcB_o,
  input  logic [DATA_WIDTH-1:0]  srcA_i,
  input  logic [DATA_WIDTH-1:0]  srcB_i,
  input  logic                   wb_we_ni,
  input  logic [SELECT_SIZE-1:0] wb_dst_i,
  input  logic [DATA_WIDTH-1:0]  wb_data_i,
  input  logic                   flush_i,
  output logic [DATA_WIDTH-1:0]  opA_o,
  output logic [DATA_WIDTH-1:0]  opB_o,
  output logic [SELECT_SIZE-1:0] rd_o,
  output logic                   op_valid_o,
  input  logic                   op_ready_i
);

  state_t                 state;
  logic [SELECT_SIZE-1:0] rs1;
  logic [SELECT_SIZE-1:0] rs2;
  logic [SELECT_SIZE-1:0] rd;
  logic [DATA_WIDTH-1:0]  value_a;
  logic [DATA_WIDTH-1:0]  value_b;
  logic                   hazard_a;
  logic                   hazard_b;
  logic                   unused_ir;

  assign rs1 = SELECT_SIZE'(ir_i[RS1_MSB:RS1_LSB]);
  assign rs2 = SELECT_SIZE'(ir_i[RS2_MSB:RS2_LSB]);
  assign rd  = SELECT_SIZE'(ir_i[RD_MSB:RD_LSB]);
  assign unused_ir = ^{ir_i[31:25], ir_i[14:12], ir_i[6:0]};

  // The read selects double as the captured rs1/rs2 for hazard detection.
  operand_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .SELECT_SIZE(SELECT_SIZE)
  ) u_sel_a (
    .sel     (reg_srcA_o),
    .rf_data (srcA_i),
    .wb_we_ni(wb_we_ni),
    .wb_dst  (wb_dst_i),
    .wb_data (wb_data_i),
    .value   (value_a),
    .hazard  (hazard_a)
  );

  operand_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .SELECT_SIZE(SELECT_SIZE)
  ) u_sel_b (
    .sel     (reg_srcB_o),
    .rf_data (srcB_i),
    .wb_we_ni(wb_we_ni),
    .wb_dst  (wb_dst_i),
    .wb_data (wb_data_i),
    .value   (value_b),
    .hazard  (hazard_b)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      op_valid_o  <= 1'b0;
      opA_o       <= '0;
      opB_o       <= '0;
      rd_o        <= '0;
      reg_srcA_o  <= '0;
      reg_srcB_o  <= '0;
    end else if (flush_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      op_valid_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            reg_srcA_o  <= rs1;
            reg_srcB_o  <= rs2;
            rd_o        <= rd;
            req_ready_o <= 1'b0;
            state       <= READ;
          end
        end
        READ: begin
`ifndef OPERAND_FETCH_BYPASS_EN
          // Stay one more cycle so the register file returns the new value.
          if (hazard_a || hazard_b) begin
            state <= READ;
          end else
`endif
          begin
            opA_o      <= value_a;
            opB_o      <= value_b;
            op_valid_o <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
`ifdef OPERAND_FETCH_BYPASS_EN
          if (hazard_a) opA_o <= value_a;
          if (hazard_b) opB_o <= value_b;
`endif
          if (op_ready_i) begin
            op_valid_o  <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          op_valid_o  <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for operand_fetch, with a behavioural
// register bank behind the read selects; honours OPERAND_FETCH_BYPASS_EN.
`default_nettype none

module tb_operand_fetch;

  localparam int DW = 32;
  localparam int SS = 5;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam int HAZ_LAT = 1;
  localparam bit BYP     = 1'b1;
`else
  localparam int HAZ_LAT = 2;
  localparam bit BYP     = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   ir;
  logic          req_valid;
  logic          req_ready;
  logic [SS-1:0] src_a_sel;
  logic [SS-1:0] src_b_sel;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic          wb_we_n;
  logic [SS-1:0] wb_dst;
  logic [DW-1:0] wb_data;
  logic          flush;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [SS-1:0] rd;
  logic          op_valid;
  logic          op_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [SS-1:0] rd;
  } exp_t;

  exp_t exp_q[$];

  logic [DW-1:0] bank [32];

  always #5 clk = ~clk;

  // Behavioural register file: combinational read, written by the snooped port.
  assign src_a = bank[src_a_sel];
  assign src_b = bank[src_b_sel];
  always @(posedge clk) if (!wb_we_n) bank[wb_dst] <= wb_data;

  operand_fetch #(.DATA_WIDTH(DW), .SELECT_SIZE(SS)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .ir_i       (ir),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .reg_srcA_o (src_a_sel),
    .reg_srcB_o (src_b_sel),
    .srcA_i     (src_a),
    .srcB_i     (src_b),
    .wb_we_ni   (wb_we_n),
    .wb_dst_i   (wb_dst),
    .wb_data_i  (wb_data),
    .flush_i    (flush),
    .opA_o      (op_a),
    .opB_o      (op_b),
    .rd_o       (rd),
    .op_valid_o (op_valid),
    .op_ready_i (op_ready)
  );

  function automatic logic [31:0] r_type(input logic [4:0] d, input logic [4:0] s1,
                                         input logic [4:0] s2);
    return {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [DW-1:0] val);
    wb_we_n = 1'b0;
    wb_dst  = idx;
    wb_data = val;
    tick();
    wb_we_n = 1'b1;
  endtask

  task automatic accept(input logic [31:0] word);
    ir        = word;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Edges after the accept edge until op_valid is seen; -1 if the budget expires.
  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (op_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_hold();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({op_valid, op_a, op_b, rd, src_a_sel, src_b_sel} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b a=%h b=%h rd=%0d sa=%0d sb=%0d, want all 0",
               op_valid, op_a, op_b, rd, src_a_sel, src_b_sel);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_basic();
    int   lat;
    exp_t e;
    write_reg(5'd5, 32'h11);
    write_reg(5'd6, 32'h22);
    exp_q.push_back('{a: 32'h11, b: 32'h22, rd: 5'd7});
    accept(r_type(5'd7, 5'd5, 5'd6));
    checks++;
    if (op_valid !== 1'b0 || req_ready !== 1'b0 || src_a_sel !== 5'd5 || src_b_sel !== 5'd6) begin
      failures++;
      $display("FAIL basic_read: got valid=%b ready=%b sa=%0d sb=%0d want 0 0 5 6",
               op_valid, req_ready, src_a_sel, src_b_sel);
    end
    wait_valid(8, lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL basic_latency: got %0d want 1", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (op_a !== e.a || op_b !== e.b || rd !== e.rd) begin
      failures++;
      $display("FAIL basic_operands: got a=%h b=%h rd=%0d want a=%h b=%h rd=%0d",
               op_a, op_b, rd, e.a, e.b, e.rd);
    end
    release_hold();
    checks++;
    if (op_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_release: got valid=%b ready=%b want 0 1", op_valid, req_ready);
    end
  endtask

  task automatic test_x0();
    int   lat;
    exp_t e;
    write_reg(5'd0, 32'hDEADBEEF);
    write_reg(5'd9, 32'h1234);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        exp_q.push_back('{a: 32'h0, b: 32'h1234, rd: 5'd3});
        accept(r_type(5'd3, 5'd0, 5'd9));
      end else begin
        exp_q.push_back('{a: 32'h1234, b: 32'h0, rd: 5'd4});
        accept(r_type(5'd4, 5'd9, 5'd0));
      end
      wait_valid(8, lat);
      e = exp_q.pop_front();
      checks++;
      if (lat !== 1 || op_a !== e.a || op_b !== e.b || rd !== e.rd) begin
        failures++;
        $display("FAIL x0_force[%0d]: got lat=%0d a=%h b=%h rd=%0d want lat=1 a=%h b=%h rd=%0d",
                 k, lat, op_a, op_b, rd, e.a, e.b, e.rd);
      end
      release_hold();
    end
  endtask

  task automatic test_hazard();
    int   lat;
    exp_t e;
    exp_q.push_back('{a: 32'h99, b: 32'h22, rd: 5'd7});
    accept(r_type(5'd7, 5'd5, 5'd6));
    wb_we_n = 1'b0;
    wb_dst  = 5'd5;
    wb_data = 32'h99;
    tick();
    wb_we_n = 1'b1;
    lat = op_valid ? 1 : -1;
    if (!op_valid) begin
      for (int i = 2; i <= 8; i++) begin
        tick();
        if (op_valid) begin
          lat = i;
          break;
        end
      end
    end
    checks++;
    if (lat !== HAZ_LAT) begin
      failures++;
      $display("FAIL hazard_latency: got %0d want %0d", lat, HAZ_LAT);
    end
    e = exp_q.pop_front();
    checks++;
    if (op_a !== e.a || op_b !== e.b || rd !== e.rd) begin
      failures++;
      $display("FAIL hazard_operands: got a=%h b=%h rd=%0d want a=%h b=%h rd=%0d",
               op_a, op_b, rd, e.a, e.b, e.rd);
    end
    // A write landing while the operands are held.
    wb_we_n = 1'b0;
    wb_dst  = 5'd6;
    wb_data = 32'h66;
    tick();
    wb_we_n = 1'b1;
    checks++;
    if (op_valid !== 1'b1 || op_b !== (BYP ? 32'h66 : 32'h22) || op_a !== 32'h99) begin
      failures++;
      $display("FAIL hazard_hold: got valid=%b a=%h b=%h want 1 a=99 b=%h",
               op_valid, op_a, op_b, BYP ? 32'h66 : 32'h22);
    end
    release_hold();
  endtask

  task automatic test_hold_stall();
    int   lat;
    exp_t e;
    bit   bad;
    exp_q.push_back('{a: 32'h99, b: 32'h66, rd: 5'd8});
    accept(r_type(5'd8, 5'd5, 5'd6));
    wait_valid(8, lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 1 || op_a !== e.a || op_b !== e.b || rd !== e.rd) begin
      failures++;
      $display("FAIL stall_operands: got lat=%0d a=%h b=%h rd=%0d want lat=1 a=%h b=%h rd=%0d",
               lat, op_a, op_b, rd, e.a, e.b, e.rd);
    end
    // A pending request during HOLD must not be taken.
    ir        = r_type(5'd12, 5'd1, 5'd2);
    req_valid = 1'b1;
    bad       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (op_valid !== 1'b1 || req_ready !== 1'b0 || op_a !== e.a || op_b !== e.b || rd !== e.rd)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stall_stable: got valid=%b ready=%b a=%h b=%h rd=%0d want 1 0 %h %h %0d",
               op_valid, req_ready, op_a, op_b, rd, e.a, e.b, e.rd);
    end
    op_ready = 1'b1;
    tick();
    op_ready  = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (op_valid !== 1'b0 || req_ready !== 1'b1 || rd !== 5'd8) begin
      failures++;
      $display("FAIL stall_release: got valid=%b ready=%b rd=%0d want 0 1 8",
               op_valid, req_ready, rd);
    end
  endtask

  task automatic test_flush();
    bit seen;
    accept(r_type(5'd7, 5'd5, 5'd6));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen  = op_valid;
    checks++;
    if (req_ready !== 1'b1 || op_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_read: got ready=%b valid=%b want 1 0", req_ready, op_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= op_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_valid: got op_valid pulse %b want 0", seen);
    end
    ir        = r_type(5'd13, 5'd5, 5'd6);
    req_valid = 1'b1;
    flush     = 1'b1;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || op_valid !== 1'b0 || rd !== 5'd7) begin
      failures++;
      $display("FAIL flush_wins: got ready=%b valid=%b rd=%0d want 1 0 7",
               req_ready, op_valid, rd);
    end
  endtask

  task automatic test_reset_in_hold();
    int lat;
    accept(r_type(5'd14, 5'd5, 5'd6));
    wait_valid(8, lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL rsthold_reach: got lat=%0d want 1", lat);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({op_valid, op_a, op_b, rd, src_a_sel, src_b_sel} !== '0) begin
      failures++;
      $display("FAIL rsthold_clear: got valid=%b a=%h b=%h rd=%0d sa=%0d sb=%0d want all 0",
               op_valid, op_a, op_b, rd, src_a_sel, src_b_sel);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || op_valid !== 1'b0) begin
      failures++;
      $display("FAIL rsthold_ready: got ready=%b valid=%b want 1 0", req_ready, op_valid);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    ir        = '0;
    req_valid = 1'b0;
    wb_we_n   = 1'b1;
    wb_dst    = '0;
    wb_data   = '0;
    flush     = 1'b0;
    op_ready  = 1'b0;
    test_reset();
    test_basic();
    test_x0();
    test_hazard();
    test_hold_stall();
    test_flush();
    test_reset_in_hold();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the operand and register data width.
REQ-002 The block SHALL have parameter SELECT_SIZE, default 5, meaning the register select width.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port ir_i, input, 32 bits: instruction word, sampled on request accept.
REQ-006 The block SHALL have port req_valid_i, input, 1 bit: fetch request valid.
REQ-007 The block SHALL have port req_ready_o, output, 1 bit: block can accept a request.
REQ-008 The block SHALL have ports reg_srcA_o and reg_srcB_o, output, SELECT_SIZE bits each: register file read selects.
REQ-009 The block SHALL have ports srcA_i and srcB_i, input, DATA_WIDTH bits each: combinational register file read data.
REQ-010 The block SHALL have ports wb_we_ni (1 bit), wb_dst_i (SELECT_SIZE bits) and wb_data_i (DATA_WIDTH bits), all inputs: a snoop of the register file write port; wb_we_ni is active-low.
REQ-011 The block SHALL have port flush_i, input, 1 bit: abort the current fetch.
REQ-012 The block SHALL have ports opA_o and opB_o, output, DATA_WIDTH bits each: the latched operands.
REQ-013 The block SHALL have port rd_o, output, SELECT_SIZE bits: the latched destination field, ir[11:7].
REQ-014 The block SHALL have port op_valid_o, output, 1 bit: the operands are valid.
REQ-015 The block SHALL have port op_ready_i, input, 1 bit: the consumer accepts the operands.

Function
REQ-016 The block SHALL implement a three-state FSM with states IDLE, READ and HOLD.
REQ-017 In IDLE, req_ready_o SHALL be 1; req_valid_i=1 SHALL capture the IR (rs1=ir[19:15], rs2=ir[24:20], rd=ir[11:7]) and move the FSM to READ.
REQ-018 In READ, reg_srcA_o and reg_srcB_o SHALL drive the captured rs1 and rs2; in every other state they SHALL hold their last value.
REQ-019 In READ, opA_o and opB_o SHALL load the read data and the FSM SHALL move to HOLD, giving op_valid_o=1 two cycles after the accept edge.
REQ-020 An operand whose select is 0 SHALL load 0 regardless of srcA_i or srcB_i.
REQ-021 In HOLD, op_valid_o SHALL be 1 and the operands SHALL stay stable; op_ready_i=1 SHALL return the FSM to IDLE.
REQ-022 req_ready_o SHALL be 0 outside IDLE, with no back-to-back accept from HOLD.
REQ-023 flush_i=1 SHALL force IDLE on the next edge from any state and SHALL clear op_valid_o.
REQ-024 If flush_i and req_valid_i are both 1 in IDLE, flush_i SHALL win and no request SHALL be accepted.
REQ-025 A write hazard SHALL be defined as wb_we_ni=0 with wb_dst_i nonzero and equal to a captured rs1 or rs2; its handling SHALL be as given in REQ-030 and REQ-031.

Reset
REQ-026 When reset_ni=0 at a rising edge, the block SHALL go to IDLE and clear op_valid_o, opA_o, opB_o, rd_o, reg_srcA_o and reg_srcB_o to 0.
REQ-027 req_ready_o SHALL be 1 in the first cycle after reset is released.
REQ-028 A reset during READ or HOLD SHALL discard the fetch, with no op_valid_o pulse.

Configuration
REQ-029 The feature SHALL be controlled by the macro OPERAND_FETCH_BYPASS_EN.
REQ-030 With OPERAND_FETCH_BYPASS_EN defined, a hazard in READ SHALL load wb_data_i into the matching operand with no added latency, and a hazard in HOLD SHALL update the matching held operand in place.
REQ-031 With OPERAND_FETCH_BYPASS_EN undefined, a hazard in READ SHALL keep the FSM in READ one extra cycle so the value is re-read, and a hazard in HOLD SHALL be ignored.

Structure
REQ-032 A shared package operand_fetch_pkg SHALL hold the state enum, the RS1, RS2 and RD field bit positions, and the X0 select constant.
REQ-033 One sub-module, operand_select, SHALL be instantiated twice, once per operand; it applies the x0 forcing and the bypass selection.

Verification
REQ-034 Bench case: bank x5=0x11, x6=0x22; accept `add x7,x5,x6` -> opA=0x11, opB=0x22, rd=7, op_valid_o=1 at accept+2.
REQ-035 Bench case: instruction with rs1=0, srcA_i=0xDEADBEEF -> opA_o=0.
REQ-036 Bench case: in READ, write x5=0x99 -> with the bypass macro, opA=0x99 at accept+2; without it, opA=0x99 at accept+3.
REQ-037 Bench case: hold op_ready_i=0 for 4 cycles -> operands stable and req_ready_o=0, then IDLE one cycle after op_ready_i=1.
REQ-038 Bench case: flush_i=1 in READ -> IDLE next cycle and op_valid_o never asserts; flush_i together with req_valid_i in IDLE -> no accept.
REQ-039 Bench case: reset_ni=0 in HOLD -> all outputs 0 and req_ready_o=1 after release.
